// File: rtl/relm_fp_normalize.sv
// rtl/relm_fp_normalize.sv - 3-stage mantissa normalize/round/pack to IEEE-754 single
// Optional round-to-nearest-even selected by `RELM_FP_RNE_EN (default build truncates).
module relm_fp_normalize #(
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WD-1:0] in_mant,
    input  logic [WD-1:0] in_info,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WD-1:0] out_data
);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic info_unused;
    assign info_unused = ^in_info[20:0];

    // Stage 1: leading-one detect
    logic [4:0] lod_k;
    always_comb begin
        lod_k = '0;
        for (int i = 0; i < WD; i++) begin
            if (in_mant[i]) lod_k = i[4:0];
        end
    end

    logic          s1_valid, s2_valid;
    logic [WD-1:0] s1_mant;
    logic [4:0]    s1_k;
    logic [7:0]    s1_exp;
    logic          s1_sign, s1_inf, s1_zero, s1_mzero;

    // Stage 2: shift the leading one to bit 31, then round below bit 8
    logic [WD-1:0]      norm;
    logic [22:0]        frac;
    logic               round_inc;
    logic [23:0]        rounded;
    logic signed [9:0]  e_norm;

    assign norm   = s1_mant << (5'd31 - s1_k);
    assign frac   = norm[30:8];
    assign e_norm = {2'b00, s1_exp} + {5'b00000, s1_k} - 10'd30;

`ifdef RELM_FP_RNE_EN
    logic guard, sticky;
    assign guard     = norm[7];
    assign sticky    = |norm[6:0];
    assign round_inc = guard & (sticky | frac[0]);
`else
    logic rnd_unused;
    assign rnd_unused = ^norm[7:0];
    assign round_inc  = 1'b0;
`endif

    assign rounded = {1'b0, frac} + {23'd0, round_inc};

    logic [22:0]       s2_frac;
    logic              s2_carry;
    logic signed [9:0] s2_e;
    logic              s2_sign, s2_inf, s2_zero, s2_mzero;

    // Stage 3: fold in the rounding carry, then saturate/flush and pack
    logic signed [9:0] e_fin;
    logic [WD-1:0]     packed_res;

    assign e_fin = s2_e + {9'd0, s2_carry};

    always_comb begin
        packed_res = {s2_sign, e_fin[7:0], s2_frac};
        if (s2_inf && s2_zero)
            packed_res = {s2_sign, 8'hFF, 1'b1, 22'd0};
        else if (s2_inf)
            packed_res = {s2_sign, 8'hFF, 23'd0};
        else if (s2_zero || s2_mzero)
            packed_res = {s2_sign, 31'd0};
        else if (e_fin >= 10'sd255)
            packed_res = {s2_sign, 8'hFF, 23'd0};
        else if (e_fin <= 10'sd0)
            packed_res = {s2_sign, 31'd0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) out_data <= packed_res;
        end
    end

    // Datapath registers carry no meaning while their valid bit is low
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_mant  <= in_mant;
            s1_k     <= lod_k;
            s1_exp   <= in_info[30:23];
            s1_sign  <= in_info[31];
            s1_inf   <= in_info[22];
            s1_zero  <= in_info[21];
            s1_mzero <= (in_mant == '0);
            s2_frac  <= rounded[22:0];
            s2_carry <= rounded[23];
            s2_e     <= e_norm;
            s2_sign  <= s1_sign;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_mzero <= s1_mzero;
        end
    end

endmodule
